// File: rtl/nibble_serial_adder_pkg.sv
// Shared arithmetic definitions for the nibble-serial adder: FSM encoding
// and the width of one datapath step.
package arith_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Request/response bundle of the nibble-serial adder; the requester uses
// the master view, the adder the slave view.
interface nibble_serial_adder_if #(
    parameter int W = 16
);

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );

endinterface

// File: rtl/nibble_serial_adder_fa4b.sv
// Team 4-bit ripple adder, purely combinational.
module fa4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    assign {cout, s} = 5'(a) + 5'(b) + 5'(cin);

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle W-bit adder: one nibble per clock through a single fa4b,
// carrying between nibbles through a registered carry.
module nibble_serial_adder
    import arith_pkg::*;
#(
    parameter int W = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    nibble_serial_adder_if.slave bus
);

    localparam int NNIB  = W / NIB_W;
    localparam int CNT_W = (NNIB > 1) ? $clog2(NNIB) : 1;

    state_t             state_q;
    state_t             state_nxt;
    logic [W-1:0]       a_sh;
    logic [W-1:0]       b_sh;
    logic [W-1:0]       sum_q;
    logic               carry_q;
    logic               cout_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NIB_W-1:0]   nib_sum;
    logic               nib_cout;
    logic               last_step;
    logic               accept;

    fa4b u_fa4b (a_sh[NIB_W-1:0], b_sh[NIB_W-1:0], carry_q, nib_sum, nib_cout);

    assign last_step = (cnt_q == CNT_W'(NNIB - 1));
    // A start is taken whenever the adder is not busy, including the DONE cycle.
    assign accept    = bus.start && (state_q != RUN);

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Sum nibbles enter from the MSB side so after NNIB steps nibble 0 sits at the bottom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_sh    <= bus.a;
            b_sh    <= bus.b;
            carry_q <= bus.cin;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            sum_q   <= W'({nib_sum, sum_q} >> NIB_W);
            a_sh    <= a_sh >> NIB_W;
            b_sh    <= b_sh >> NIB_W;
            carry_q <= nib_cout;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (last_step) begin
                cout_q <= nib_cout;
            end
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder at W=16 and W=4: vector table,
// hand-built corner sequences and a queue-based result scoreboard.
module tb_nibble_serial_adder;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          done_cnt16 = 0;
    int          done_cnt4 = 0;
    int          done_before;
    logic [16:0] q16[$];
    logic [4:0]  q4[$];
    logic [16:0] exp16;
    logic [4:0]  exp4;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        rc;
    vec_t        vecs[7];

    always #5 clk = ~clk;

    nibble_serial_adder_if #(.W(16)) bus16 ();
    nibble_serial_adder_if #(.W(4))  bus4 ();

    nibble_serial_adder #(.W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));
    nibble_serial_adder #(.W(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                 input logic [16:0] expected, input bit accepted);
        bus16.a     = a;
        bus16.b     = b;
        bus16.cin   = cin;
        bus16.start = 1'b1;
        if (accepted) q16.push_back(expected);
        @(negedge clk);
        bus16.start = 1'b0;
    endtask

    task automatic applyStimulus4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                                  input logic [4:0] expected);
        bus4.a     = a;
        bus4.b     = b;
        bus4.cin   = cin;
        bus4.start = 1'b1;
        q4.push_back(expected);
        @(negedge clk);
        bus4.start = 1'b0;
    endtask

    // Every cycle between the accepting edge and done must show busy.
    task automatic waitDone16(input string name, input int first, input int exp_lat);
        int lat = first;
        int busy_cycles = 0;
        while (bus16.done !== 1'b1 && lat < 40) begin
            if (bus16.busy === 1'b1) busy_cycles++;
            @(negedge clk);
            lat++;
        end
        checkOutput({name, "_latency"}, (bus16.done === 1'b1) ? 32'(lat) : 32'hFFFF_FFFF, 32'(exp_lat));
        checkOutput({name, "_busy"}, 32'(busy_cycles), 32'(exp_lat - first));
    endtask

    task automatic waitDone4(input string name, input int exp_lat);
        int lat = 1;
        while (bus4.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({name, "_latency"}, (bus4.done === 1'b1) ? 32'(lat) : 32'hFFFF_FFFF, 32'(exp_lat));
    endtask

    always @(negedge clk) begin
        if (rst_n && bus16.done === 1'b1) begin
            done_cnt16++;
            checkOutput("sb16_pending", 32'(q16.size() > 0), 32'd1);
            if (q16.size() > 0) begin
                exp16 = q16.pop_front();
                checkOutput("sum16", 32'(bus16.sum), 32'(exp16[15:0]));
                checkOutput("cout16", 32'(bus16.cout), 32'(exp16[16]));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus4.done === 1'b1) begin
            done_cnt4++;
            checkOutput("sb4_pending", 32'(q4.size() > 0), 32'd1);
            if (q4.size() > 0) begin
                exp4 = q4.pop_front();
                checkOutput("sum4", 32'(bus4.sum), 32'(exp4[3:0]));
                checkOutput("cout4", 32'(bus4.cout), 32'(exp4[4]));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vecs[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[3] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
        vecs[4] = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0};
        vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};

        bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;
        bus4.start  = 1'b0; bus4.a  = '0; bus4.b  = '0; bus4.cin  = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 32'(bus16.busy), 32'd0);
        checkOutput("reset_done", 32'(bus16.done), 32'd0);
        checkOutput("reset_sum", 32'(bus16.sum), 32'd0);
        checkOutput("reset_cout", 32'(bus16.cout), 32'd0);
        checkOutput("reset_busy4", 32'(bus4.busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] vector table, W=16");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].cout, vecs[i].sum}, 1'b1);
            waitDone16("vec", 1, 5);
            @(negedge clk);
            checkOutput("vec_done_pulse", 32'(bus16.done), 32'd0);
            checkOutput("vec_idle", 32'(bus16.busy), 32'd0);
            checkOutput("vec_hold", 32'({bus16.cout, bus16.sum}), 32'({vecs[i].cout, vecs[i].sum}));
        end

        $display("[TB] back-to-back start in the DONE cycle");
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, 1'b1);
        waitDone16("b2b_first", 1, 5);
        applyStimulus(16'h000E, 16'h0005, 1'b0, 17'h00013, 1'b1);
        waitDone16("b2b_second", 1, 5);
        @(negedge clk);

        $display("[TB] start while busy is ignored");
        done_before = done_cnt16;
        applyStimulus(16'h1111, 16'h2222, 1'b0, 17'h03333, 1'b1);
        @(negedge clk);
        applyStimulus(16'h5555, 16'h5555, 1'b0, 17'h0AAAA, 1'b0);
        waitDone16("ignored", 3, 5);
        repeat (8) @(negedge clk);
        checkOutput("ignored_single_done", 32'(done_cnt16 - done_before), 32'd1);
        checkOutput("ignored_hold", 32'({bus16.cout, bus16.sum}), 32'h03333);

        $display("[TB] reset abort in second RUN cycle");
        applyStimulus(16'hABCD, 16'h1234, 1'b1, 17'h0BE02, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(bus16.busy), 32'd0);
        checkOutput("abort_done", 32'(bus16.done), 32'd0);
        checkOutput("abort_sum", 32'(bus16.sum), 32'd0);
        checkOutput("abort_cout", 32'(bus16.cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_before = done_cnt16;
        repeat (8) @(negedge clk);
        checkOutput("abort_no_done", 32'(done_cnt16 - done_before), 32'd0);
        applyStimulus(16'h00FF, 16'h0001, 1'b0, 17'h00100, 1'b1);
        waitDone16("after_abort", 1, 5);
        @(negedge clk);

        $display("[TB] W=4 directed and randomized");
        applyStimulus4(4'hE, 4'h5, 1'b0, 5'h13);
        waitDone4("w4_directed", 2);
        @(negedge clk);
        for (int i = 0; i < 200; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rc = 1'($urandom_range(0, 1));
            applyStimulus4(ra, rb, rc, 5'(ra) + 5'(rb) + 5'(rc));
            waitDone4("w4_rand", 2);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        checkOutput("w4_done_count", 32'(done_cnt4), 32'd201);

        checkOutput("sb16_empty", 32'(q16.size()), 32'd0);
        checkOutput("sb4_empty", 32'(q4.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
